// File: rtl/uart_tx_buf.sv
// uart_tx_buf: buffered 8N1 UART transmitter, byte FIFO in front of a serialiser
module uart_tx_buf #(
    parameter int CLKS_PER_BIT = 1250,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic                          i_clk,
    input  logic                          i_rst_n,
    input  logic [7:0]                    i_data,
    input  logic                          i_valid,
    output logic                          o_ready,
    output logic                          o_data,
    output logic                          o_busy,
    output logic                          o_done,
    output logic [$clog2(FIFO_DEPTH):0]   o_count
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int BW = $clog2(CLKS_PER_BIT);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] START = 2'd1;
    localparam logic [1:0] DATA  = 2'd2;
    localparam logic [1:0] STOP  = 2'd3;
    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] rd_ptr, wr_ptr;
    logic [CW-1:0] count;
    logic [1:0]    state;
    logic [BW-1:0] baud;
    logic [2:0]    idx;
    logic [7:0]    shift;
    logic          tx, done, wr, pop, baud_last;
    assign o_ready   = count != CW'(FIFO_DEPTH);
    assign wr        = i_valid && o_ready;
    assign baud_last = baud == BW'(CLKS_PER_BIT - 1);
    assign pop       = (count != '0) && (state == IDLE || (state == STOP && baud_last));
    assign o_count   = count;
    assign o_data    = tx;
    assign o_done    = done;
    assign o_busy    = state != IDLE;
    // FIFO storage needs no reset; pointers decide what is valid
    always_ff @(posedge i_clk) begin
        if (wr) mem[wr_ptr] <= i_data;
    end
    // FIFO pointers and occupancy; a simultaneous write and pop leaves count unchanged
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr) wr_ptr <= wr_ptr + AW'(1);
            if (pop) rd_ptr <= rd_ptr + AW'(1);
            if (wr && !pop) count <= count + CW'(1);
            else if (pop && !wr) count <= count - CW'(1);
        end
    end
    // Frame sequencer: start bit, 8 data bits LSB first, stop bit, chaining frames while data is queued
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= IDLE;
            baud  <= '0;
            idx   <= '0;
            shift <= '0;
            tx    <= 1'b1;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            baud <= (state == IDLE || baud_last) ? '0 : baud + BW'(1);
            case (state)
                IDLE: if (pop) begin
                    shift <= mem[rd_ptr];
                    state <= START;
                    tx    <= 1'b0;
                end
                START: if (baud_last) begin
                    state <= DATA;
                    idx   <= '0;
                    tx    <= shift[0];
                end
                DATA: if (baud_last) begin
                    shift <= shift >> 1;
                    tx    <= (idx == 3'd7) ? 1'b1 : shift[1];
                    state <= (idx == 3'd7) ? STOP : DATA;
                    idx   <= idx + 3'd1;
                end
                STOP: if (baud_last) begin
                    done  <= 1'b1;
                    tx    <= !pop;
                    state <= pop ? START : IDLE;
                    if (pop) shift <= mem[rd_ptr];
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx_buf.sv
// tb_uart_tx_buf: self-checking bench for uart_tx_buf against a queue/frame-time reference model
module tb_uart_tx_buf;
    localparam int CPB   = 4;
    localparam int DEPTH = 4;
    localparam int FRAME = 10 * CPB;
    typedef struct {
        int   off;
        logic d;
        logic b;
        logic dn;
        int   cnt;
    } vec_t;
    logic       i_clk = 1'b0;
    logic       i_rst_n = 1'b0;
    logic       i_valid = 1'b0;
    logic [7:0] i_data = 8'h00;
    logic       o_ready, o_data, o_busy, o_done;
    logic [$clog2(DEPTH):0] o_count;
    int checks = 0;
    int errors = 0;
    byte unsigned mq[$];
    bit         m_act = 1'b0;
    bit         m_done = 1'b0;
    int         m_t = 0;
    logic [7:0] m_cur = 8'h00;
    int cyc = 0;
    int peak = 0;
    int accepted = 0;
    bit saw_unready = 1'b0;
    bit low_seen = 1'b0;
    int done_cyc[$];
    byte unsigned rxq[$];
    bit         rx_act = 1'b0;
    int         rx_t = 0;
    logic [7:0] rx_b = 8'h00;
    vec_t tbl[17];

    uart_tx_buf #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_data(i_data), .i_valid(i_valid),
        .o_ready(o_ready), .o_data(o_data), .o_busy(o_busy), .o_done(o_done), .o_count(o_count)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 'h%0h, required 'h%0h", name, act, exp);
        end
    endtask

    // expected line level from the frame position: bit slot 0 start, 1..8 data, 9 stop
    function automatic logic exp_line();
        int b;
        if (!m_act) return 1'b1;
        b = m_t / CPB;
        if (b == 0) return 1'b0;
        if (b == 9) return 1'b1;
        return m_cur[b-1];
    endfunction

    task automatic model_clear();
        mq.delete();
        m_act = 1'b0;
        m_done = 1'b0;
        m_t = 0;
        rx_act = 1'b0;
    endtask

    task automatic step();
        bit wr, pop;
        logic [7:0] a, e;
        wr = i_rst_n && i_valid && (mq.size() != DEPTH);
        @(posedge i_clk);
        cyc++;
        if (i_rst_n) begin
            pop = (mq.size() > 0) && (!m_act || m_t == FRAME - 1);
            m_done = m_act && (m_t == FRAME - 1);
            if (m_act) begin
                m_t++;
                if (m_t == FRAME) m_act = 1'b0;
            end
            if (pop) begin
                m_cur = mq.pop_front();
                m_act = 1'b1;
                m_t = 0;
            end
            if (wr) begin
                mq.push_back(i_data);
                accepted++;
            end
        end
        #1;
        a = {1'b0, o_data, o_busy, o_done, o_ready, o_count};
        e = {1'b0, exp_line(), m_act, m_done, mq.size() != DEPTH, 3'(mq.size())};
        chk("cycle{data,busy,done,ready,count}", 32'(a), 32'(e));
        if (int'(o_count) > peak) peak = int'(o_count);
        if (!o_ready) saw_unready = 1'b1;
        if (!o_data) low_seen = 1'b1;
        if (o_done) done_cyc.push_back(cyc);
        if (!i_rst_n) rx_act = 1'b0;
        else if (!rx_act) begin
            if (o_data === 1'b0) begin
                rx_act = 1'b1;
                rx_t = 0;
            end
        end else begin
            rx_t++;
            if (rx_t > CPB && rx_t < 9 * CPB && rx_t % CPB == CPB / 2) rx_b[rx_t / CPB - 1] = o_data;
            if (rx_t == 9 * CPB + CPB / 2) begin
                chk("stop_bit", 32'(o_data), 32'd1);
                rxq.push_back(rx_b);
                rx_act = 1'b0;
            end
        end
    endtask

    task automatic do_reset();
        i_rst_n = 1'b0;
        i_valid = 1'b0;
        #1;
        model_clear();
        chk("rst_data", 32'(o_data), 32'd1);
        chk("rst_busy", 32'(o_busy), 32'd0);
        chk("rst_done", 32'(o_done), 32'd0);
        chk("rst_count", 32'(o_count), 32'd0);
        chk("rst_ready", 32'(o_ready), 32'd1);
        step();
        step();
        i_rst_n = 1'b1;
    endtask

    task automatic send(input logic [7:0] b);
        i_valid = 1'b1;
        i_data = b;
        step();
        i_valid = 1'b0;
    endtask

    initial begin
        int off, w0, k, prev;
        tbl = '{
            '{0, 1'b1, 1'b0, 1'b0, 1}, '{1, 1'b0, 1'b1, 1'b0, 0}, '{4, 1'b0, 1'b1, 1'b0, 0},
            '{5, 1'b1, 1'b1, 1'b0, 0}, '{9, 1'b0, 1'b1, 1'b0, 0}, '{13, 1'b1, 1'b1, 1'b0, 0},
            '{17, 1'b0, 1'b1, 1'b0, 0}, '{21, 1'b0, 1'b1, 1'b0, 0}, '{24, 1'b0, 1'b1, 1'b0, 0},
            '{25, 1'b1, 1'b1, 1'b0, 0}, '{29, 1'b0, 1'b1, 1'b0, 0}, '{33, 1'b1, 1'b1, 1'b0, 0},
            '{36, 1'b1, 1'b1, 1'b0, 0}, '{37, 1'b1, 1'b1, 1'b0, 0}, '{40, 1'b1, 1'b1, 1'b0, 0},
            '{41, 1'b1, 1'b0, 1'b1, 0}, '{42, 1'b1, 1'b0, 1'b0, 0}
        };
        repeat (2) @(posedge i_clk);
        #1;
        do_reset();
        repeat (3) step();

        // single frame of A5 against the hand-derived timing table
        send(8'hA5);
        off = 0;
        foreach (tbl[i]) begin
            while (off < tbl[i].off) begin
                step();
                off++;
            end
            chk($sformatf("a5_data@%0d", off), 32'(o_data), 32'(tbl[i].d));
            chk($sformatf("a5_busy@%0d", off), 32'(o_busy), 32'(tbl[i].b));
            chk($sformatf("a5_done@%0d", off), 32'(o_done), 32'(tbl[i].dn));
            chk($sformatf("a5_count@%0d", off), 32'(o_count), 32'(tbl[i].cnt));
        end

        // three back-to-back frames
        peak = 0;
        done_cyc.delete();
        rxq.delete();
        send(8'h01);
        w0 = cyc;
        send(8'hFF);
        send(8'h00);
        repeat (130) step();
        chk("b2b_done_n", 32'(done_cyc.size()), 32'd3);
        for (int i = 0; i < 3 && i < done_cyc.size(); i++)
            chk($sformatf("b2b_done%0d", i), 32'(done_cyc[i] - w0), 32'(41 + 40 * i));
        chk("b2b_peak", 32'(peak), 32'd2);
        chk("b2b_rx_n", 32'(rxq.size()), 32'd3);
        if (rxq.size() == 3) begin
            chk("b2b_rx0", 32'(rxq[0]), 32'h01);
            chk("b2b_rx1", 32'(rxq[1]), 32'hFF);
            chk("b2b_rx2", 32'(rxq[2]), 32'h00);
        end

        // saturate the FIFO with incrementing data
        peak = 0;
        saw_unready = 1'b0;
        accepted = 0;
        rxq.delete();
        i_valid = 1'b1;
        i_data = 8'h00;
        repeat (200) begin
            prev = accepted;
            step();
            if (accepted != prev) i_data = i_data + 8'd1;
        end
        i_valid = 1'b0;
        repeat (12 * FRAME) step();
        chk("full_peak", 32'(peak), 32'(DEPTH));
        chk("full_unready", 32'(saw_unready), 32'd1);
        chk("full_rx_n", 32'(rxq.size()), 32'(accepted));
        foreach (rxq[i]) chk($sformatf("full_rx%0d", i), 32'(rxq[i]), 32'(i % 256));

        // reset in the middle of a frame with bytes still queued
        send(8'h3C);
        send(8'h11);
        send(8'h22);
        chk("mid_queued", 32'(o_count), 32'd2);
        repeat (15) step();
        chk("mid_busy", 32'(o_busy), 32'd1);
        do_reset();
        low_seen = 1'b0;
        rxq.delete();
        repeat (60) step();
        chk("post_rst_low", 32'(low_seen), 32'd0);
        chk("post_rst_rx", 32'(rxq.size()), 32'd0);

        // write coinciding with the pop at the end of a stop bit while one byte is queued
        rxq.delete();
        send(8'h5A);
        send(8'hC3);
        repeat (39) step();
        chk("bnd_pre_count", 32'(o_count), 32'd1);
        send(8'h77);
        chk("bnd_count", 32'(o_count), 32'd1);
        chk("bnd_start", 32'(o_data), 32'd0);
        repeat (100) step();
        chk("bnd_rx_n", 32'(rxq.size()), 32'd3);
        if (rxq.size() == 3) begin
            chk("bnd_rx0", 32'(rxq[0]), 32'h5A);
            chk("bnd_rx1", 32'(rxq[1]), 32'hC3);
            chk("bnd_rx2", 32'(rxq[2]), 32'h77);
        end

        // random traffic checked cycle by cycle against the model
        repeat (2000) begin
            i_valid = ($urandom % 4) == 0;
            i_data = 8'($urandom);
            step();
        end
        i_valid = 1'b0;
        repeat (6 * FRAME) step();

        // loopback through the bench's serial decoder: all byte values in order
        do_reset();
        rxq.delete();
        k = 0;
        i_data = 8'h00;
        i_valid = 1'b1;
        for (int n = 0; n < 20000 && k < 256; n++) begin
            prev = accepted;
            step();
            if (accepted != prev) k++;
            i_data = 8'(k);
        end
        i_valid = 1'b0;
        repeat (6 * FRAME) step();
        chk("loop_rx_n", 32'(rxq.size()), 32'd256);
        foreach (rxq[i]) chk($sformatf("loop_rx%0d", i), 32'(rxq[i]), 32'(i));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/uart_tx_buf.md
Name: uart_tx_buf

Overview:
- Buffered 8N1 UART transmitter; the transmit-direction counterpart of uart_rx on the Bluetooth serial link.
- Accepts bytes from fabric logic over a valid/ready handshake into an internal FIFO.
- Serialises bytes onto the TX pin toward the BT module, back-to-back while data is queued.
- Signalling conventions match uart_rx: line idles high; o_done is a one-cycle completion pulse.

Parameters:
- CLKS_PER_BIT, 1250, i_clk cycles per bit (12 MHz / 9600 baud); minimum legal value 2.
- FIFO_DEPTH, 16, byte FIFO entries; power of two, at least 2.

Ports:
- i_clk  in  1  system clock; all logic on its rising edge.
- i_rst_n  in  1  asynchronous active-low reset.
- i_data  in  8  byte to queue.
- i_valid  in  1  i_data is presented for write.
- o_ready  out  1  FIFO can accept a byte this cycle.
- o_data  out  1  serial TX line, registered.
- o_busy  out  1  high while a frame is on the line.
- o_done  out  1  one-cycle pulse at the end of each stop bit.
- o_count  out  $clog2(FIFO_DEPTH)+1  bytes currently queued, excluding the byte in flight.

Behaviour:
- Reset (asynchronous, takes effect immediately):
  - Outputs: o_data=1, o_busy=0, o_done=0, o_count=0, o_ready=1.
  - FIFO pointers cleared; FSM to IDLE; bit and baud counters cleared.
  - Reset mid-frame aborts the frame and returns the line high at once. The aborted byte and all queued bytes are discarded.
- Handshake:
  - A write occurs on a rising edge when i_valid && o_ready.
  - o_ready = (o_count != FIFO_DEPTH), combinational from the registered count.
  - i_valid while full is ignored. The FIFO contents are unaffected and no error flag is raised.
- Pop: occurs on an edge where the FSM is in IDLE, or at the final cycle of STOP, and the FIFO is non-empty.
- Simultaneous write and pop: both take effect and o_count is unchanged.
- When full, a pop raises o_ready in the cycle after the pop edge.
- FSM states: IDLE, START, DATA, STOP. Each bit lasts exactly CLKS_PER_BIT cycles, timed by a baud counter running 0..CLKS_PER_BIT-1.
  - IDLE: o_data=1, o_busy=0. If the FIFO is non-empty: pop into the shift register, go to START, o_data=0 from the next cycle.
  - START: hold o_data=0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
  - DATA: drive the shift register LSB first, bit index 0..7, each for CLKS_PER_BIT cycles. After bit 7 go to STOP.
  - STOP: o_data=1 for CLKS_PER_BIT cycles. On the last cycle, pulse o_done high for exactly one cycle (the cycle after that edge). Then:
    - FIFO non-empty: pop and enter START directly, no idle bit between frames.
    - FIFO empty: go to IDLE.
- Timing:
  - Latency: a write to an empty FIFO in IDLE at edge N drives o_data low after edge N+1.
  - Frame length is exactly 10*CLKS_PER_BIT cycles.
  - o_busy is high from the first START cycle through the last STOP cycle.
- Widths:
  - o_count counts 0..FIFO_DEPTH without wrap.
  - FIFO pointers are $clog2(FIFO_DEPTH) bits and wrap modulo FIFO_DEPTH.
  - Baud counter is $clog2(CLKS_PER_BIT) bits.
- o_data is driven only from a flop, with no combinational path from i_data.

Test Plan:
- CLKS_PER_BIT=4, reset, write 8'hA5 once.
  - o_data low one cycle after the write edge.
  - Then 4-cycle bits 1,0,1,0,0,1,0,1, then stop high.
  - o_done pulses once, 40 cycles after the start bit begins; o_busy falls after it.
- Write 8'h01, 8'hFF, 8'h00 on consecutive cycles.
  - Three frames back-to-back with no extra idle cycles; o_done pulses at cycles 40, 80, 120.
  - o_count peaks at 2, since byte 1 is popped the cycle after it is written.
- FIFO_DEPTH=4, hold i_valid with incrementing data while a frame is in flight.
  - o_count saturates at 4 with o_ready=0; extra writes are dropped.
  - Transmitted sequence contains no skipped or duplicated bytes.
  - o_ready returns the cycle after the next pop.
- Assert i_rst_n=0 mid-DATA of 8'h3C with 2 bytes queued.
  - o_data=1, o_busy=0, o_count=0 immediately.
  - After release, no frame is sent until a new write.
- Loopback: connect o_data to uart_rx i_data with a matching bit rate and send 0x00..0xFF.
  - The receiver reports each byte in order with one o_done per byte.
- Simultaneous write and pop at a STOP-end boundary with o_count=1.
  - o_count stays 1; the next frame carries the older byte.
